// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT stage scheduler (mod 65537 datapath).
package ntt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  localparam int unsigned PRIME = 65537;
  localparam int unsigned M     = 16;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((32'd1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/ntt_wb_delay.sv
// Write-back delay line: valid + address pair shifted DEPTH cycles, never stalled.
module ntt_wb_delay
  import ntt_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic         pending
);

  logic [DEPTH-1:0] vld;
  logic [W-1:0]     a_q [DEPTH];
  logic [W-1:0]     b_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      vld[0] <= in_valid;
      a_q[0] <= in_a;
      b_q[0] <= in_b;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        a_q[i] <= a_q[i-1];
        b_q[i] <= b_q[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_a     = a_q[DEPTH-1];
  assign out_b     = b_q[DEPTH-1];

  // Pending excludes the output stage: an entry there is leaving this cycle,
  // so the next stage may read on the following cycle without a RAW hazard.
  always_comb begin
    pending = in_valid;
    for (int unsigned i = 0; i + 1 < DEPTH; i++) pending = pending | vld[i];
  end

endmodule

// File: rtl/ntt_stage_scheduler.sv
// Radix-2 DIT NTT address/twiddle scheduler with stage barrier and write-back replay.
// Optional inverse twiddle indexing when NTT_INV_EN is defined (adds port inv).
module ntt_stage_scheduler
  import ntt_pkg::*;
#(
  parameter int unsigned N      = 256,
  parameter int unsigned LOG_N  = 8,
  parameter int unsigned BF_LAT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             hold,
`ifdef NTT_INV_EN
  input  logic             inv,
`endif
  output logic             busy,
  output logic             done,
  output logic [LOG_N-1:0] stage,
  output logic             rd_en,
  output logic [LOG_N-1:0] rd_addr_a,
  output logic [LOG_N-1:0] rd_addr_b,
  output logic [LOG_N-1:0] tw_addr,
  output logic             wr_en,
  output logic [LOG_N-1:0] wr_addr_a,
  output logic [LOG_N-1:0] wr_addr_b
);

  localparam int unsigned JW = clog2(N / 2);
  localparam logic [JW-1:0]    J_LAST     = JW'(N / 2 - 1);
  localparam logic [LOG_N-1:0] STAGE_LAST = LOG_N'(LOG_N - 1);

  typedef struct packed {
    logic [LOG_N-1:0] a;
    logic [LOG_N-1:0] b;
    logic [LOG_N-1:0] tw;
  } bf_t;

  function automatic bf_t bf_addr(input logic [LOG_N-1:0] s, input logic [JW-1:0] jj);
    bf_t              r;
    logic [LOG_N-1:0] jx;
    logic [LOG_N-1:0] half;
    logic [LOG_N-1:0] k;
    jx   = LOG_N'(jj);
    half = LOG_N'(1) << s;
    k    = jx & (half - LOG_N'(1));
    r.a  = ((jx >> s) << (s + LOG_N'(1))) + k;
    r.b  = r.a + half;
    r.tw = k << (LOG_N'(LOG_N - 1) - s);
    return r;
  endfunction

  state_t           state;
  logic [JW-1:0]    j;
  logic             pending;
  logic [LOG_N-1:0] issue_s;
  logic [JW-1:0]    issue_j;
  bf_t              nxt;
  logic [LOG_N-1:0] tw_next;
`ifdef NTT_INV_EN
  logic             inv_q;
  logic             inv_eff;
`endif

  // The butterfly registered on this edge depends on where it is issued from:
  // start (stage 0), normal issue, or the drain exit into the next stage.
  always_comb begin
    issue_s = stage;
    issue_j = j;
    if (state == IDLE) begin
      issue_s = '0;
      issue_j = '0;
    end else if (state == DRAIN) begin
      issue_s = stage + LOG_N'(1);
      issue_j = '0;
    end
    nxt = bf_addr(issue_s, issue_j);
`ifdef NTT_INV_EN
    inv_eff = (state == IDLE) ? inv : inv_q;
    tw_next = inv_eff ? (LOG_N'(0) - nxt.tw) : nxt.tw;
`else
    tw_next = nxt.tw;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      stage     <= '0;
      j         <= '0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
`ifdef NTT_INV_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      done  <= 1'b0;
      rd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            stage     <= '0;
            j         <= JW'(1);
            rd_en     <= 1'b1;
            rd_addr_a <= nxt.a;
            rd_addr_b <= nxt.b;
            tw_addr   <= tw_next;
`ifdef NTT_INV_EN
            inv_q     <= inv;
`endif
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!hold) begin
            rd_en     <= 1'b1;
            rd_addr_a <= nxt.a;
            rd_addr_b <= nxt.b;
            tw_addr   <= tw_next;
            if (j == J_LAST) state <= DRAIN;
            else             j     <= j + JW'(1);
          end
        end
        DRAIN: begin
          if (!pending) begin
            if (stage == STAGE_LAST) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              stage     <= stage + LOG_N'(1);
              j         <= JW'(1);
              rd_en     <= 1'b1;
              rd_addr_a <= nxt.a;
              rd_addr_b <= nxt.b;
              tw_addr   <= tw_next;
              state     <= ISSUE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  ntt_wb_delay #(
    .W     (LOG_N),
    .DEPTH (BF_LAT)
  ) u_wb_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_en),
    .in_a      (rd_addr_a),
    .in_b      (rd_addr_b),
    .out_valid (wr_en),
    .out_a     (wr_addr_a),
    .out_b     (wr_addr_b),
    .pending   (pending)
  );

endmodule
